// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: shared UART receive definitions.
// FSM states, frame width and small helpers.
package uart_receiver_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received-byte holding register handshake.
// master drives byte/flags, slave drives ready.
interface uart_receiver_if;
  import uart_receiver_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider for sample ticks.
// One-clk tick every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick
  import uart_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int W   = div_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Divider counter, wraps at its terminal count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receive path, 16x oversampled.
// Start check, 3-sample vote, stop check, holding register.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            RxD,
  output logic            busy,
  uart_receiver_if.master rx
);

  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int IDLE_W = $clog2(OVERSAMPLE + 1);
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [SAMP_W-1:0] S_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] S_V0   = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] S_V1   = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] S_V2   = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [IDLE_W-1:0] I_FULL = IDLE_W'(OVERSAMPLE);
  localparam logic [IDX_W-1:0]  X_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rxs;
  logic                 tick;
  state_t               state;
  state_t               state_nx;
  logic [SAMP_W-1:0]    samp;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [IDX_W-1:0]     idx;
  logic [1:0]           vote;
  logic [DATA_BITS-1:0] shift;
  logic                 deliver;
  logic                 maj;
  logic                 samp_last;
  logic                 idle_ok;
  logic                 stop_ok;
  logic                 stop_bad;

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Two-flop synchroniser; the line idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
    end
  end

  assign maj       = maj3(vote[0], vote[1], rxs);
  assign samp_last = (samp == S_LAST);
  // A full bit of high line: 16 tick periods, i.e. the 17th
  // consecutive high sample, so a lone high data bit never qualifies.
  assign idle_ok   = rxs && (idle_cnt == I_FULL);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode, advanced on sample ticks only
  always_comb begin
    state_nx = state;
    if (tick) begin
      unique case (state)
        WAIT_IDLE: if (idle_ok) state_nx = IDLE;
        IDLE:      if (!rxs) state_nx = START;
        START: begin
          if (samp == S_V0 && rxs) state_nx = IDLE;
          else if (samp_last) state_nx = DATA;
        end
        DATA: begin
          if (samp_last && idx == X_LAST) state_nx = STOP;
        end
        STOP: begin
          if (samp == S_V2) state_nx = maj ? IDLE : WAIT_IDLE;
        end
        default: state_nx = WAIT_IDLE;
      endcase
    end
  end

  // Output decode: busy and the stop-bit verdict
  always_comb begin
    busy     = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (1'b1)
      (state == START),
      (state == DATA): busy = 1'b1;
      (state == STOP): begin
        busy     = 1'b1;
        stop_ok  = tick && (samp == S_V2) && maj;
        stop_bad = tick && (samp == S_V2) && !maj;
      end
      default: ;
    endcase
  end

  // Sample/idle counters, bit index, votes and shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp     <= '0;
      idle_cnt <= '0;
      idx      <= '0;
      vote     <= '0;
      shift    <= '0;
    end else if (tick) begin
      samp <= samp_last ? '0 : samp + 1'b1;
      unique case (state)
        WAIT_IDLE: begin
          samp     <= '0;
          idle_cnt <= (!rxs || idle_ok) ? '0 : idle_cnt + 1'b1;
        end
        IDLE: begin
          samp     <= rxs ? '0 : SAMP_W'(1);
          idx      <= '0;
          idle_cnt <= '0;
        end
        START: begin
          if (samp == S_V0 && rxs) samp <= '0;
        end
        DATA, STOP: begin
          if (samp == S_V0) vote[0] <= rxs;
          if (samp == S_V1) vote[1] <= rxs;
          if (state == DATA && samp == S_V2) shift[idx] <= maj;
          if (state == DATA && samp_last && idx != X_LAST) idx <= idx + 1'b1;
          if (state == STOP && samp == S_V2) samp <= '0;
        end
        default: ;
      endcase
    end
  end

  // Delivery strobe and framing pulse, one clk after the stop decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deliver      <= 1'b0;
      rx.frame_err <= 1'b0;
    end else begin
      deliver      <= stop_ok;
      rx.frame_err <= stop_bad;
    end
  end

  // Holding register: load, drop-with-overrun, or accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx.data    <= '0;
      rx.valid   <= 1'b0;
      rx.overrun <= 1'b0;
    end else if (deliver) begin
      if (!rx.valid || rx.ready) begin
        rx.data  <= shift;
        rx.valid <= 1'b1;
      end else begin
        rx.overrun <= 1'b1;
      end
    end else if (rx.valid && rx.ready) begin
      rx.valid   <= 1'b0;
      rx.overrun <= 1'b0;
    end
  end

endmodule
